instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 155 +++++++++++++++
 tb/tb_instr_fetch.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit: IDLE/FETCH/HOLD/DRAIN/FAULT sequencer with redirect support.
// Optional misaligned-redirect trap enabled by defining IFETCH_MISALIGN_CHK_EN.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        fetch_fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_DRAIN,
    S_FAULT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic        imem_req_q, imem_req_d;
  logic [31:0] target_pc;

`ifdef IFETCH_MISALIGN_CHK_EN
  logic        fetch_fault_q, fetch_fault_d;
  logic        outstanding_q, outstanding_d;
  logic        misaligned;

  assign target_pc  = redirect_pc;
  assign misaligned = |redirect_pc[1:0];
`else
  assign target_pc  = {redirect_pc[31:2], 2'b00};
`endif

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
`ifdef IFETCH_MISALIGN_CHK_EN
    fetch_fault_d = fetch_fault_q;
    // Tracks a request still in flight so leaving FAULT cannot overlap it.
    if (imem_rvalid) begin
      outstanding_d = 1'b0;
    end else if (state_q == S_FETCH) begin
      outstanding_d = 1'b1;
    end else begin
      outstanding_d = outstanding_q;
    end
`endif

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_rvalid) begin
          instr_d       = imem_rdata;
          instr_pc_d    = fetch_pc_q;
          instr_valid_d = 1'b1;
          fetch_pc_d    = fetch_pc_q + 32'd4;
          state_d       = S_HOLD;
        end
      end
      S_HOLD: begin
        if (instr_valid_q && instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (imem_rvalid) begin
          state_d = S_FETCH;
        end
      end
`ifdef IFETCH_MISALIGN_CHK_EN
      S_FAULT: state_d = S_FAULT;
`endif
      default: state_d = S_IDLE;
    endcase

    // Redirect overrides everything above, including a same-cycle capture.
    if (redirect) begin
      fetch_pc_d    = target_pc;
      instr_valid_d = 1'b0;
      case (state_q)
        S_FETCH, S_DRAIN: state_d = imem_rvalid ? S_FETCH : S_DRAIN;
`ifdef IFETCH_MISALIGN_CHK_EN
        S_FAULT: state_d = (outstanding_q && !imem_rvalid) ? S_DRAIN : S_FETCH;
`endif
        default: state_d = S_FETCH;
      endcase
`ifdef IFETCH_MISALIGN_CHK_EN
      if (misaligned) begin
        state_d       = S_FAULT;
        fetch_fault_d = 1'b1;
      end else begin
        fetch_fault_d = 1'b0;
      end
`endif
    end

    imem_req_d = (state_d == S_FETCH);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      fetch_pc_q    <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
`ifdef IFETCH_MISALIGN_CHK_EN
      fetch_fault_q <= 1'b0;
      outstanding_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      imem_req_q    <= imem_req_d;
`ifdef IFETCH_MISALIGN_CHK_EN
      fetch_fault_q <= fetch_fault_d;
      outstanding_q <= outstanding_d;
`endif
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = fetch_pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
`ifdef IFETCH_MISALIGN_CHK_EN
  assign fetch_fault = fetch_fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequential fetch, stall, drain, redirect races, PC wrap, misaligned redirect.
module tb_instr_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        req0, req1;
  logic [31:0] addr0, addr1;
  logic [1:0]  rvalid;
  logic [31:0] rdata [2];
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ready0;
  logic [31:0] instr0, instr1, pc0, pc1;
  logic        valid0, valid1, fault0, fault1;

  instr_fetch u_dut (
    .clk         (clk),
    .resetn      (resetn),
    .imem_req    (req0),
    .imem_addr   (addr0),
    .imem_rvalid (rvalid[0]),
    .imem_rdata  (rdata[0]),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr0),
    .instr_pc    (pc0),
    .instr_valid (valid0),
    .instr_ready (ready0),
    .fetch_fault (fault0)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk         (clk),
    .resetn      (resetn),
    .imem_req    (req1),
    .imem_addr   (addr1),
    .imem_rvalid (rvalid[1]),
    .imem_rdata  (rdata[1]),
    .redirect    (1'b0),
    .redirect_pc (32'h0),
    .instr       (instr1),
    .instr_pc    (pc1),
    .instr_valid (valid1),
    .instr_ready (1'b1),
    .fetch_fault (fault1)
  );

  int          lat [2];
  bit          busy [2];
  int          cnt [2];
  logic [31:0] acc_addr [2];
  logic [31:0] acc_log[$];
  logic [31:0] hs_pc0[$];
  logic [31:0] hs_instr0[$];
  logic [31:0] hs_pc1[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  // Memory model: accepts a request, answers after lat cycles with data = addr + 0x13.
  initial begin
    rvalid = '0;
    rdata[0] = '0;
    rdata[1] = '0;
    busy[0] = 1'b0;
    busy[1] = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      for (int c = 0; c < 2; c++) begin
        bit          just;
        logic        r;
        logic [31:0] a;
        just = 1'b0;
        r = (c == 0) ? req0 : req1;
        a = (c == 0) ? addr0 : addr1;
        rvalid[c] = 1'b0;
        if (!resetn) begin
          busy[c] = 1'b0;
        end else begin
          if (busy[c]) begin
            cnt[c] = cnt[c] - 1;
            if (cnt[c] == 0) begin
              rvalid[c] = 1'b1;
              rdata[c]  = acc_addr[c] + 32'h13;
              busy[c]   = 1'b0;
              just      = 1'b1;
            end
          end
          if (!just && !busy[c] && r) begin
            busy[c]     = 1'b1;
            cnt[c]      = lat[c];
            acc_addr[c] = a;
            if (c == 0) acc_log.push_back(a);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (resetn) begin
        if (valid0 && ready0) begin
          hs_pc0.push_back(pc0);
          hs_instr0.push_back(instr0);
        end
        if (valid1) hs_pc1.push_back(pc1);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn      = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    tick(2);
    acc_log.delete();
    hs_pc0.delete();
    hs_instr0.delete();
    hs_pc1.delete();
    resetn = 1'b1;
  endtask

  task automatic wait_req_addr(input string tag, input logic [31:0] a);
    for (int k = 0; k < 60 && !(req0 && addr0 == a); k++) tick(1);
    chk(tag, 32'(req0 && addr0 == a), 32'd1);
  endtask

  task automatic wait_hs(input string tag, input int n);
    for (int k = 0; k < 100 && hs_pc0.size() < n; k++) tick(1);
    chk(tag, 32'(hs_pc0.size() >= n), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    for (int k = 0; k < 30 && !valid0; k++) tick(1);
    chk(tag, 32'(valid0), 32'd1);
  endtask

  initial begin
    resetn      = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    ready0      = 1'b1;
    lat[0]      = 1;
    lat[1]      = 1;
    tick(3);

    chk("rst_req", 32'(req0), 32'd0);
    chk("rst_valid", 32'(valid0), 32'd0);
    chk("rst_instr", instr0, 32'h0);
    chk("rst_pc", pc0, 32'h0);
    chk("rst_fault", 32'(fault0), 32'd0);
    chk("rst_addr", addr0, 32'h0);
    chk("rst_wrap_addr", addr1, 32'hFFFF_FFFC);
    chk("rst_wrap_req", 32'(req1), 32'd0);

    // Sequential fetch, single-cycle memory, always ready.
    resetn = 1'b1;
    wait_hs("seq_hs", 3);
    chk("seq_addr0", acc_log[0], 32'h0);
    chk("seq_addr1", acc_log[1], 32'h4);
    chk("seq_addr2", acc_log[2], 32'h8);
    chk("seq_pc0", hs_pc0[0], 32'h0);
    chk("seq_pc1", hs_pc0[1], 32'h4);
    chk("seq_pc2", hs_pc0[2], 32'h8);
    chk("seq_instr0", hs_instr0[0], 32'h13);
    chk("wrap_pc0", hs_pc1[0], 32'hFFFF_FFFC);
    chk("wrap_pc1", hs_pc1[1], 32'h0);

    // Decoder stall: instruction held, no new request.
    ready0 = 1'b0;
    do_reset();
    wait_valid("stall_valid");
    for (int i = 0; i < 5; i++) begin
      chk("stall_instr", instr0, 32'h13);
      chk("stall_pc", pc0, 32'h0);
      chk("stall_hold_valid", 32'(valid0), 32'd1);
      chk("stall_req", 32'(req0), 32'd0);
      tick(1);
    end
    ready0 = 1'b1;
    tick(1);
    chk("stall_rel_req", 32'(req0), 32'd1);
    chk("stall_rel_addr", addr0, 32'h4);
    chk("stall_rel_valid", 32'(valid0), 32'd0);
    chk("stall_rel_hs", 32'(hs_pc0.size()), 32'd1);

    // Redirect with a 3-cycle request outstanding: drain and discard.
    lat[0] = 3;
    do_reset();
    wait_req_addr("drain_req8", 32'h8);
    begin
      int n0;
      n0 = hs_pc0.size();
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      tick(1);
      redirect = 1'b0;
      for (int i = 0; i < 3; i++) begin
        chk("drain_req", 32'(req0), 32'd0);
        chk("drain_valid", 32'(valid0), 32'd0);
        tick(1);
      end
      chk("drain_next_req", 32'(req0), 32'd1);
      chk("drain_next_addr", addr0, 32'h100);
      wait_hs("drain_hs", n0 + 1);
      chk("drain_hs_pc", hs_pc0[n0], 32'h100);
      chk("drain_hs_instr", hs_instr0[n0], 32'h113);
    end

    // Redirect coincident with the response: data dropped, no drain.
    lat[0] = 1;
    do_reset();
    wait_req_addr("race_req0", 32'h0);
    tick(1);
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    tick(1);
    redirect = 1'b0;
    chk("race_req", 32'(req0), 32'd1);
    chk("race_addr", addr0, 32'h200);
    chk("race_valid", 32'(valid0), 32'd0);
    wait_hs("race_hs", 1);
    chk("race_hs_pc", hs_pc0[0], 32'h200);
    chk("race_hs_instr", hs_instr0[0], 32'h213);

    // Redirect coincident with the HOLD handshake.
    ready0 = 1'b0;
    do_reset();
    wait_valid("hold_valid");
    ready0      = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    tick(1);
    redirect = 1'b0;
    chk("hold_rd_valid", 32'(valid0), 32'd0);
    chk("hold_rd_req", 32'(req0), 32'd1);
    chk("hold_rd_addr", addr0, 32'h300);
    chk("hold_rd_hs0", hs_pc0[0], 32'h0);
    wait_hs("hold_rd_hs", 2);
    chk("hold_rd_hs1", hs_pc0[1], 32'h300);

    // Misaligned redirect target.
    do_reset();
    wait_req_addr("mis_req0", 32'h0);
    redirect    = 1'b1;
    redirect_pc = 32'h102;
    tick(1);
    redirect = 1'b0;
`ifdef IFETCH_MISALIGN_CHK_EN
    chk("mis_fault", 32'(fault0), 32'd1);
    chk("mis_req", 32'(req0), 32'd0);
    chk("mis_valid", 32'(valid0), 32'd0);
    tick(3);
    chk("mis_fault_hold", 32'(fault0), 32'd1);
    chk("mis_req_hold", 32'(req0), 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h104;
    tick(1);
    redirect = 1'b0;
    chk("mis_clr_fault", 32'(fault0), 32'd0);
    chk("mis_clr_req", 32'(req0), 32'd1);
    chk("mis_clr_addr", addr0, 32'h104);
    wait_hs("mis_hs", 1);
    chk("mis_hs_pc", hs_pc0[0], 32'h104);
`else
    chk("mis_fault", 32'(fault0), 32'd0);
    chk("mis_drain_req", 32'(req0), 32'd0);
    wait_req_addr("mis_req100", 32'h100);
    chk("mis_fault_after", 32'(fault0), 32'd0);
    wait_hs("mis_hs", 1);
    chk("mis_hs_pc", hs_pc0[0], 32'h100);
    chk("mis_hs_instr", hs_instr0[0], 32'h113);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
